// File: rtl/prach_hb5_ctrl.sv
// Phase sequencer ahead of the PRACH HB5 half-band decimator: buffers even-phase
// samples per channel and emits even/odd polyphase pairs as a 2:1 TDM stream.
module prach_hb5_ctrl #(
  parameter int NUM_CHANNEL = 48,
  parameter int DW          = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] s_dq,
  input  logic          s_dv,
  input  logic [7:0]    s_chn,
  input  logic          s_sync,
  output logic [DW-1:0] m_dp1,
  output logic [DW-1:0] m_dp2,
  output logic          m_dv,
  output logic [7:0]    m_chn,
  output logic          m_sync,
  output logic          err_seq,
  input  logic          clr_err,
  output logic          locked
);

  localparam int         AW       = (NUM_CHANNEL > 1) ? $clog2(NUM_CHANNEL) : 1;
  localparam logic [7:0] LAST_CHN = 8'(NUM_CHANNEL - 1);

  typedef enum logic [1:0] {
    HUNT = 2'd0,
    EVEN = 2'd1,
    ODD  = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [7:0]    exp_chn_q, exp_chn_d;
  logic          sync_arm_q, sync_arm_d;
  logic          err_q, err_d;
  logic          locked_q, locked_d;

  // Stage 1: beat registered alongside the buffer read
  logic          p_dv_q, p_dv_d;
  logic          p_sync_q, p_sync_d;
  logic [DW-1:0] p_dq_q, p_dq_d;
  logic [7:0]    p_chn_q, p_chn_d;
  logic [DW-1:0] rd_data_q;

  // Stage 2: output register
  logic          m_dv_q, m_dv_d;
  logic          m_sync_q, m_sync_d;
  logic [DW-1:0] m_dp1_q, m_dp1_d;
  logic [DW-1:0] m_dp2_q, m_dp2_d;
  logic [7:0]    m_chn_q, m_chn_d;

  logic          wr_en;
  logic          rd_en;
  logic          new_err;
  logic          sync_hit;
  logic          chn_last;
  logic [7:0]    chn_next;
  logic [AW-1:0] buf_addr;

  logic [DW-1:0] sample_buf [NUM_CHANNEL];

  assign sync_hit = s_dv && s_sync && (s_chn == 8'd0);
  assign chn_last = (s_chn == LAST_CHN);
  assign chn_next = chn_last ? 8'd0 : s_chn + 8'd1;
  assign buf_addr = s_chn[AW-1:0];

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    state_d    = state_q;
    exp_chn_d  = exp_chn_q;
    sync_arm_d = sync_arm_q;
    wr_en      = 1'b0;
    rd_en      = 1'b0;
    new_err    = 1'b0;
    p_dv_d     = 1'b0;
    p_sync_d   = 1'b0;
    p_dq_d     = s_dq;
    p_chn_d    = s_chn;

    if (sync_hit) begin
      // A sync on channel 0 always restarts alignment as an even-phase beat.
      wr_en      = 1'b1;
      sync_arm_d = 1'b1;
      exp_chn_d  = chn_next;
      state_d    = chn_last ? ODD : EVEN;
    end else if (s_dv && (state_q != HUNT)) begin
      if (s_sync || (s_chn != exp_chn_q)) begin
        new_err   = 1'b1;
        exp_chn_d = 8'd0;
        state_d   = HUNT;
      end else if (state_q == EVEN) begin
        wr_en     = 1'b1;
        exp_chn_d = chn_next;
        if (chn_last) state_d = ODD;
      end else begin
        rd_en     = 1'b1;
        p_dv_d    = 1'b1;
        exp_chn_d = chn_next;
        if ((s_chn == 8'd0) && sync_arm_q) begin
          p_sync_d   = 1'b1;
          sync_arm_d = 1'b0;
        end
        if (chn_last) state_d = EVEN;
      end
    end

    // A new error wins over a coincident clear.
    err_d    = (err_q && !clr_err) || new_err;
    locked_d = (state_d != HUNT);

    m_dv_d   = p_dv_q;
    m_sync_d = p_dv_q && p_sync_q;
    m_dp1_d  = m_dp1_q;
    m_dp2_d  = m_dp2_q;
    m_chn_d  = m_chn_q;
    if (p_dv_q) begin
      m_dp1_d = rd_data_q;
      m_dp2_d = p_dq_q;
      m_chn_d = p_chn_q;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= HUNT;
      exp_chn_q  <= 8'd0;
      sync_arm_q <= 1'b0;
      err_q      <= 1'b0;
      locked_q   <= 1'b0;
      p_dv_q     <= 1'b0;
      p_sync_q   <= 1'b0;
      p_dq_q     <= '0;
      p_chn_q    <= 8'd0;
      m_dv_q     <= 1'b0;
      m_sync_q   <= 1'b0;
      m_dp1_q    <= '0;
      m_dp2_q    <= '0;
      m_chn_q    <= 8'd0;
    end else begin
      state_q    <= state_d;
      exp_chn_q  <= exp_chn_d;
      sync_arm_q <= sync_arm_d;
      err_q      <= err_d;
      locked_q   <= locked_d;
      p_dv_q     <= p_dv_d;
      p_sync_q   <= p_sync_d;
      p_dq_q     <= p_dq_d;
      p_chn_q    <= p_chn_d;
      m_dv_q     <= m_dv_d;
      m_sync_q   <= m_sync_d;
      m_dp1_q    <= m_dp1_d;
      m_dp2_q    <= m_dp2_d;
      m_chn_q    <= m_chn_d;
    end
  end

  // NOTE: the sample buffer is not reset; every entry is written before it is read.
  // A write and a read never share a cycle, so a read one cycle after a write to
  // the same channel already sees the new data.
  always_ff @(posedge clk) begin
    if (wr_en) sample_buf[buf_addr] <= s_dq;
    if (rd_en) rd_data_q <= sample_buf[buf_addr];
  end

  assign m_dp1   = m_dp1_q;
  assign m_dp2   = m_dp2_q;
  assign m_dv    = m_dv_q;
  assign m_chn   = m_chn_q;
  assign m_sync  = m_sync_q;
  assign err_seq = err_q;
  assign locked  = locked_q;

endmodule

// File: tb/tb_prach_hb5_ctrl.sv
// Directed self-checking bench for prach_hb5_ctrl: aligned/gapped streams,
// sequence errors, re-sync, error clear and mid-frame reset.
module tb_prach_hb5_ctrl;

  localparam int NCH = 48;
  localparam int DW  = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] s_dq;
  logic          s_dv;
  logic [7:0]    s_chn;
  logic          s_sync;
  logic [DW-1:0] m_dp1;
  logic [DW-1:0] m_dp2;
  logic          m_dv;
  logic [7:0]    m_chn;
  logic          m_sync;
  logic          err_seq;
  logic          clr_err;
  logic          locked;

  prach_hb5_ctrl #(.NUM_CHANNEL(NCH), .DW(DW)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .s_dq    (s_dq),
    .s_dv    (s_dv),
    .s_chn   (s_chn),
    .s_sync  (s_sync),
    .m_dp1   (m_dp1),
    .m_dp2   (m_dp2),
    .m_dv    (m_dv),
    .m_chn   (m_chn),
    .m_sync  (m_sync),
    .err_seq (err_seq),
    .clr_err (clr_err),
    .locked  (locked)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] dp1;
    logic [DW-1:0] dp2;
    logic [7:0]    chn;
    logic          sync;
    int            cyc;
  } pair_t;

  pair_t exp_q[$];
  int    cyc      = 0;
  int    n_dv     = 0;
  int    n_checks = 0;
  int    n_errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  // Expected sample pattern: {phase, channel}
  function automatic logic [DW-1:0] dq(input int ph, input int c);
    return {ph[7:0], c[7:0]};
  endfunction

  always @(negedge clk) begin
    if (m_dv) begin
      n_dv++;
      if (exp_q.size() == 0) begin
        check("unexp_dv", 32'(m_chn), 32'hFFFF_FFFF);
      end else begin
        pair_t e;
        e = exp_q.pop_front();
        check("dp1", 32'(m_dp1), 32'(e.dp1));
        check("dp2", 32'(m_dp2), 32'(e.dp2));
        check("chn", 32'(m_chn), 32'(e.chn));
        check("msync", 32'(m_sync), 32'(e.sync));
        check("latency", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drive one beat; if a pair is expected, it must appear two edges after capture.
  task automatic beat(input logic [DW-1:0] d, input int c, input logic sy,
                      input logic want_pair, input logic [DW-1:0] e_dp1, input logic e_sync);
    pair_t p;
    s_dv   = 1'b1;
    s_dq   = d;
    s_chn  = 8'(c);
    s_sync = sy;
    if (want_pair) begin
      p.dp1  = e_dp1;
      p.dp2  = d;
      p.chn  = 8'(c);
      p.sync = e_sync;
      p.cyc  = cyc + 2;
      exp_q.push_back(p);
    end
    @(posedge clk);
    #1;
    s_dv   = 1'b0;
    s_sync = 1'b0;
  endtask

  task automatic send_frame(input int ph, input logic sync0, input logic pairs,
                            input logic msync, input logic gaps, input int lo, input int hi);
    for (int c = lo; c <= hi; c++) begin
      if (gaps && ($urandom_range(0, 1) == 1)) idle($urandom_range(1, 2));
      beat(dq(ph, c), c, sync0 && (c == 0), pairs, dq(ph - 1, c), msync && (c == 0));
    end
  endtask

  int base;

  initial begin
    rst_n   = 1'b0;
    s_dv    = 1'b0;
    s_dq    = '0;
    s_chn   = 8'd0;
    s_sync  = 1'b0;
    clr_err = 1'b0;
    idle(2);
    check("rst_dp1", 32'(m_dp1), 0);
    check("rst_dp2", 32'(m_dp2), 0);
    check("rst_dv", 32'(m_dv), 0);
    check("rst_chn", 32'(m_chn), 0);
    check("rst_sync", 32'(m_sync), 0);
    check("rst_err", 32'(err_seq), 0);
    check("rst_locked", 32'(locked), 0);
    rst_n = 1'b1;
    idle(2);

    // Unsynced traffic in HUNT is ignored
    send_frame(8'hAA, 1'b0, 1'b0, 1'b0, 1'b0, 0, 5);
    check("hunt_locked", 32'(locked), 0);
    check("hunt_err", 32'(err_seq), 0);

    // Aligned gapless stream, four frames
    base = n_dv;
    beat(dq(0, 0), 0, 1'b1, 1'b0, '0, 1'b0);
    check("lock_after_sync", 32'(locked), 1);
    send_frame(0, 1'b0, 1'b0, 1'b0, 1'b0, 1, NCH - 1);
    send_frame(1, 1'b0, 1'b1, 1'b1, 1'b0, 0, NCH - 1);
    send_frame(2, 1'b0, 1'b0, 1'b0, 1'b0, 0, NCH - 1);
    send_frame(3, 1'b0, 1'b1, 1'b0, 1'b0, 0, NCH - 1);
    idle(4);
    check("aligned_pairs", 32'(n_dv - base), 96);
    check("aligned_err", 32'(err_seq), 0);
    check("aligned_locked", 32'(locked), 1);

    // Same stream shape with random input gaps, re-synced at its first beat
    base = n_dv;
    send_frame(4, 1'b1, 1'b0, 1'b0, 1'b1, 0, NCH - 1);
    send_frame(5, 1'b0, 1'b1, 1'b1, 1'b1, 0, NCH - 1);
    send_frame(6, 1'b0, 1'b0, 1'b0, 1'b1, 0, NCH - 1);
    send_frame(7, 1'b0, 1'b1, 1'b0, 1'b1, 0, NCH - 1);
    idle(4);
    check("gap_pairs", 32'(n_dv - base), 96);
    check("gap_err", 32'(err_seq), 0);

    // Channel skip (10 after 8) inside an ODD frame
    base = n_dv;
    send_frame(8, 1'b0, 1'b0, 1'b0, 1'b0, 0, NCH - 1);
    send_frame(9, 1'b0, 1'b1, 1'b0, 1'b0, 0, 8);
    beat(dq(9, 10), 10, 1'b0, 1'b0, '0, 1'b0);
    check("skip_err", 32'(err_seq), 1);
    check("skip_locked", 32'(locked), 0);
    send_frame(9, 1'b0, 1'b0, 1'b0, 1'b0, 11, NCH - 1);
    idle(4);
    check("skip_pairs", 32'(n_dv - base), 9);
    check("skip_still_unlocked", 32'(locked), 0);

    // Re-lock after the error; err_seq stays sticky until cleared
    base = n_dv;
    send_frame(10, 1'b1, 1'b0, 1'b0, 1'b0, 0, NCH - 1);
    send_frame(11, 1'b0, 1'b1, 1'b1, 1'b0, 0, NCH - 1);
    idle(4);
    check("relock_pairs", 32'(n_dv - base), 48);
    check("err_sticky", 32'(err_seq), 1);
    clr_err = 1'b1;
    idle(1);
    clr_err = 1'b0;
    check("clr_err", 32'(err_seq), 0);
    check("clr_locked", 32'(locked), 1);

    // clr_err coincident with a new error keeps err_seq set
    send_frame(12, 1'b0, 1'b0, 1'b0, 1'b0, 0, 4);
    clr_err = 1'b1;
    beat(dq(12, 7), 7, 1'b0, 1'b0, '0, 1'b0);
    clr_err = 1'b0;
    check("clr_vs_err", 32'(err_seq), 1);
    check("clr_vs_err_locked", 32'(locked), 0);

    // Re-sync in the middle of an EVEN frame
    clr_err = 1'b1;
    idle(1);
    clr_err = 1'b0;
    base = n_dv;
    send_frame(13, 1'b1, 1'b0, 1'b0, 1'b0, 0, 20);
    send_frame(14, 1'b1, 1'b0, 1'b0, 1'b0, 0, NCH - 1);
    send_frame(15, 1'b0, 1'b1, 1'b1, 1'b0, 0, NCH - 1);
    idle(4);
    check("resync_pairs", 32'(n_dv - base), 48);
    check("resync_err", 32'(err_seq), 0);

    // One-cycle reset in the middle of an ODD frame
    base = n_dv;
    send_frame(16, 1'b0, 1'b0, 1'b0, 1'b0, 0, NCH - 1);
    send_frame(17, 1'b0, 1'b1, 1'b0, 1'b0, 0, 9);
    idle(4);
    check("pre_rst_dp1", 32'(m_dp1), 32'(dq(16, 9)));
    rst_n = 1'b0;
    #2;
    check("arst_dp1", 32'(m_dp1), 0);
    check("arst_dp2", 32'(m_dp2), 0);
    check("arst_chn", 32'(m_chn), 0);
    check("arst_locked", 32'(locked), 0);
    idle(1);
    rst_n = 1'b1;
    send_frame(17, 1'b0, 1'b0, 1'b0, 1'b0, 10, NCH - 1);
    check("post_rst_locked", 32'(locked), 0);
    send_frame(18, 1'b1, 1'b0, 1'b0, 1'b0, 0, NCH - 1);
    send_frame(19, 1'b0, 1'b1, 1'b1, 1'b0, 0, NCH - 1);
    idle(4);
    check("rst_pairs", 32'(n_dv - base), 58);
    check("left_over", 32'(exp_q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
